// File: rtl/mem_readback_unit.sv
// Sequenced memory readback: walks an address range (wrapping past the top),
// presents each word on a valid/ready port and keeps a running checksum.
module mem_readback_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] out_value,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // state   | meaning
  // IDLE    | waiting for start; checksum holds last pass result
  // FETCH   | cursor driven onto mem_addr, memory read launched
  // CAPTURE | registered memory word latched into out_value/out_addr
  // PRESENT | out_valid high, waiting for out_ready
  // FINISH  | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              mem_rd_q, mem_rd_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    last_d      = last_q;
    out_addr_d  = out_addr_q;
    out_value_d = out_value_q;
    checksum_d  = checksum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          cursor_d   = first_addr;
          last_d     = last_addr;
          checksum_d = '0;
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        out_value_d = mem_data_in;
        out_addr_d  = cursor_q;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          checksum_d = checksum_q + out_value_q;
          if (cursor_q == last_q) begin
            state_d = FINISH;
          end else begin
            cursor_d = cursor_q + ADDR_W'(1);
            state_d  = FETCH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides any transfer happening on the same edge.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cursor_d   = cursor_q;
      checksum_d = checksum_q;
    end

    // Outputs are registered from the next state so they line up with it.
    mem_rd_d    = (state_d == FETCH) || (state_d == CAPTURE);
    out_valid_d = (state_d == PRESENT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      last_q      <= '0;
      out_addr_q  <= '0;
      out_value_q <= '0;
      checksum_q  <= '0;
      mem_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      last_q      <= last_d;
      out_addr_q  <= out_addr_d;
      out_value_q <= out_value_d;
      checksum_q  <= checksum_d;
      mem_rd_q    <= mem_rd_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = cursor_q;
  assign mem_rd    = mem_rd_q;
  assign out_value = out_value_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_readback_unit.sv
// Directed bench for mem_readback_unit with a registered-read memory model.
module tb_mem_readback_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data_in;
  logic [7:0] out_value;
  logic [3:0] out_addr;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  logic [7:0] mem [16];

  int vectors = 0;
  int errors  = 0;

  logic [7:0] got_val[$];
  logic [3:0] got_addr[$];
  int         valid_cyc[$];
  int         ndone;
  logic       rd1;
  logic [3:0] addr1;

  mem_readback_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data_in(mem_data_in),
    .out_value  (out_value),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data_in <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one pass with out_ready held high, recording transfers and done pulses.
  task automatic run_pass(input logic [3:0] f, input logic [3:0] l, input int budget);
    int   cyc;
    logic prev_valid;
    got_val.delete();
    got_addr.delete();
    valid_cyc.delete();
    ndone      = 0;
    first_addr = f;
    last_addr  = l;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    rd1        = mem_rd;
    addr1      = mem_addr;
    cyc        = 1;
    prev_valid = 1'b0;
    while (busy && (cyc < budget)) begin
      if (out_valid && !prev_valid) valid_cyc.push_back(cyc);
      prev_valid = out_valid;
      if (done) ndone++;
      if (out_valid && out_ready) begin
        got_val.push_back(out_value);
        got_addr.push_back(out_addr);
      end
      tick();
      cyc++;
    end
    check("pass_timeout", 32'(busy), 32'(0));
  endtask

  function automatic logic [31:0] qval(input int i);
    return (i < got_val.size()) ? 32'(got_val[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qaddr(input int i);
    return (i < got_addr.size()) ? 32'(got_addr[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [7:0] exp_v [4];
    logic [3:0] exp_a [4];
    int v0, v1;

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);

    @(negedge clk);
    @(negedge clk);
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_mem_rd",    32'(mem_rd),    32'(0));
    check("rst_mem_addr",  32'(mem_addr),  32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_done",      32'(done),      32'(0));
    check("rst_checksum",  32'(checksum),  32'(0));
    rst_n = 1'b1;
    tick();

    // mem = addr*3, range 2..5
    run_pass(4'd2, 4'd5, 60);
    v0 = (valid_cyc.size() > 0) ? valid_cyc[0] : -1;
    v1 = (valid_cyc.size() > 1) ? valid_cyc[1] : -1;
    check("p1_fetch_rd",   32'(rd1),   32'(1));
    check("p1_fetch_addr", 32'(addr1), 32'(2));
    check("p1_latency",    32'(v0),    32'(3));
    check("p1_spacing",    32'(v1 - v0), 32'(3));
    check("p1_nwords",     32'(got_val.size()), 32'(4));
    exp_v = '{8'd6, 8'd9, 8'd12, 8'd15};
    exp_a = '{4'd2, 4'd3, 4'd4, 4'd5};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p1_val%0d", i),  qval(i),  32'(exp_v[i]));
      check($sformatf("p1_addr%0d", i), qaddr(i), 32'(exp_a[i]));
    end
    check("p1_done_cnt", 32'(ndone),    32'(1));
    check("p1_checksum", 32'(checksum), 32'd42);
    tick();
    tick();
    check("p1_cs_hold",  32'(checksum), 32'd42);
    check("p1_idle_rd",  32'(mem_rd),   32'(0));

    // mem = addr, wrapping range 14..1
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_pass(4'd14, 4'd1, 60);
    exp_v = '{8'd14, 8'd15, 8'd0, 8'd1};
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    check("p2_nwords", 32'(got_val.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p2_val%0d", i),  qval(i),  32'(exp_v[i]));
      check($sformatf("p2_addr%0d", i), qaddr(i), 32'(exp_a[i]));
    end
    check("p2_checksum", 32'(checksum), 32'd30);

    // single word with consumer stall
    mem[7]     = 8'hFF;
    out_ready  = 1'b0;
    first_addr = 4'd7;
    last_addr  = 4'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("p3_valid%0d", i), 32'(out_valid), 32'(1));
      check($sformatf("p3_value%0d", i), 32'(out_value), 32'hFF);
      check($sformatf("p3_addr%0d", i),  32'(out_addr),  32'd7);
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    check("p3_done",      32'(done),      32'(1));
    check("p3_fin_valid", 32'(out_valid), 32'(0));
    check("p3_fin_rd",    32'(mem_rd),    32'(0));
    check("p3_fin_addr",  32'(mem_addr),  32'd7);
    check("p3_checksum",  32'(checksum),  32'hFF);
    tick();
    check("p3_idle_busy", 32'(busy),      32'(0));
    check("p3_done_low",  32'(done),      32'(0));

    // checksum overflow, full address range
    for (int i = 0; i < 16; i++) mem[i] = 8'h80;
    run_pass(4'd0, 4'd15, 120);
    check("p4_nwords",   32'(got_val.size()), 32'(16));
    check("p4_done_cnt", 32'(ndone),    32'(1));
    check("p4_checksum", 32'(checksum), 32'h00);

    // abort in PRESENT with simultaneous ready
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
    first_addr = 4'd2;
    last_addr  = 4'd5;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("p5_first_val", 32'(out_value), 32'd6);
    tick();
    tick();
    tick();
    check("p5_second_valid", 32'(out_valid), 32'(1));
    check("p5_second_val",   32'(out_value), 32'd9);
    check("p5_cs_before",    32'(checksum),  32'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("p5_abort_busy",  32'(busy),      32'(0));
    check("p5_abort_valid", 32'(out_valid), 32'(0));
    check("p5_abort_done",  32'(done),      32'(0));
    check("p5_abort_cs",    32'(checksum),  32'd6);
    tick();
    check("p5_no_late_done", 32'(done),     32'(0));
    check("p5_cs_hold",      32'(checksum), 32'd6);

    // reset during CAPTURE; start ignored while busy
    first_addr = 4'd0;
    last_addr  = 4'd3;
    start      = 1'b1;
    tick();
    first_addr = 4'd9;
    last_addr  = 4'd9;
    tick();
    start = 1'b0;
    check("p6_capture_rd",   32'(mem_rd),   32'(1));
    check("p6_start_ignored", 32'(mem_addr), 32'd0);
    rst_n = 1'b0;
    #1;
    check("p6_rst_busy",     32'(busy),      32'(0));
    check("p6_rst_rd",       32'(mem_rd),    32'(0));
    check("p6_rst_addr",     32'(mem_addr),  32'(0));
    check("p6_rst_value",    32'(out_value), 32'(0));
    check("p6_rst_out_addr", 32'(out_addr),  32'(0));
    check("p6_rst_checksum", 32'(checksum),  32'(0));
    @(negedge clk);
    @(negedge clk);
    check("p6_held_valid", 32'(out_valid), 32'(0));
    first_addr = 4'd4;
    last_addr  = 4'd4;
    start      = 1'b1;
    rst_n      = 1'b1;
    tick();
    start = 1'b0;
    check("p6_first_start_busy", 32'(busy),     32'(1));
    check("p6_first_start_addr", 32'(mem_addr), 32'd4);
    tick();
    tick();
    check("p6_value",    32'(out_value), 32'd12);
    tick();
    check("p6_done",     32'(done),      32'(1));
    check("p6_checksum", 32'(checksum),  32'd12);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
